tinytpu_mm_engine: RTL and testbench

Parametrised successor to the single-lane tinytpu core. It receives two signed NxN operand matrices over LANES-bit serial buses and computes Z = X·Y on an NxN array of MAC cells. It then streams Z back out serially, and the receiver can stall the output stream. It sits directly behind the tt_um pin wrapper, which maps ui_in/uo_out bits onto these ports.

---
 rtl/tinytpu_pkg.sv | 31 +++
 rtl/tinytpu_mac_cell.sv | 38 +++
 rtl/tinytpu_mm_engine.sv | 196 +++++++++++++++++++
 tb/tb_tinytpu_mm_engine.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tinytpu_pkg.sv
// Shared types and elaboration helpers for the tinytpu matrix-multiply engine.
package tinytpu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    READY   = 3'd2,
    COMPUTE = 3'd3,
    TX      = 3'd4
  } state_e;

  // Smallest accumulator that can hold a sum of n full-scale signed products.
  function automatic int min_acc_w(input int d_w, input int n);
    return 2 * d_w + $clog2(n);
  endfunction

  // Number of LANES-wide chunks needed to move elems elements of elem_w bits.
  function automatic int chunk_count(input int elems, input int elem_w, input int lanes);
    return (elems * elem_w) / lanes;
  endfunction

  // Width of a down-counter that must hold values 0 .. max(a,b,c)-1.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tinytpu_mac_cell.sv
// One signed D_W x D_W multiply-accumulate cell with synchronous clear/enable.
// acc_nxt_o is the value the accumulator takes on the next enabled edge, so the
// top can capture the final sum in the same cycle as the last accumulation.
module tinytpu_mac_cell #(
  parameter int D_W   = 8,
  parameter int ACC_W = 17
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [D_W-1:0]   a_i,
  input  logic signed [D_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] acc_nxt_o
);

  logic signed [2*D_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  assign prod      = a_i * b_i;
  assign prod_ext  = ACC_W'(prod);
  assign acc_nxt_o = acc_q + prod_ext;

  // Next accumulator value: clear has priority over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_nxt_o;
  end

  // Accumulator register.
  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/tinytpu_mm_engine.sv
// tinytpu matrix-multiply engine: serial load of X and Y, N-cycle compute on an
// NxN MAC array, serial stream-out of Z with receiver stall.
// Optional macro TINYTPU_RELU_EN: clamp negative Z elements to 0 before TX.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for the first operand chunk
// LOAD    | shifting in X/Y chunks, counter holds chunks left minus one
// READY   | operands held, load_done=1, waiting for init or a reload
// COMPUTE | N accumulate cycles, counter runs N-1 down to 0
// TX      | streaming Z MSB-first, counter holds chunks left minus one
module tinytpu_mm_engine
  import tinytpu_pkg::*;
#(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int LANES = 1,
  parameter int ACC_W = tinytpu_pkg::min_acc_w(D_W, N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] data_in_x,
  input  logic [LANES-1:0] data_in_y,
  input  logic             load_en,
  input  logic             init,
  input  logic             tx_hold,
  output logic [LANES-1:0] data_out_z,
  output logic             tx_ready,
  output logic             load_done,
  output logic             busy
);

  localparam int NN    = N * N;
  localparam int OP_W  = NN * D_W;
  localparam int Z_W   = NN * ACC_W;
  localparam int LB    = chunk_count(NN, D_W, LANES);
  localparam int TB    = chunk_count(NN, ACC_W, LANES);
  localparam int CNT_W = cnt_width(LB, TB, N);

  if ((D_W % LANES) != 0) begin : g_bad_lanes_d
    $error("LANES must divide D_W");
  end
  if ((ACC_W % LANES) != 0) begin : g_bad_lanes_acc
    $error("LANES must divide ACC_W");
  end
  if (ACC_W < min_acc_w(D_W, N)) begin : g_bad_acc_w
    $error("ACC_W is below 2*D_W+clog2(N)");
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OP_W-1:0]         x_sr_q, x_sr_d;
  logic [OP_W-1:0]         y_sr_q, y_sr_d;
  logic [Z_W-1:0]          z_sr_q, z_sr_d;
  logic [Z_W-1:0]          z_load;

  logic signed [D_W-1:0]   x_col [N];
  logic signed [D_W-1:0]   y_row [N];
  logic signed [ACC_W-1:0] acc_nxt [N][N];

  logic load_fire;
  logic load_last;
  logic start;
  logic cnt_zero;

  // First chunk arrives from IDLE/READY; in LOAD the counter says when we are done.
  assign load_fire = load_en && ((state_q == IDLE) || (state_q == LOAD) ||
                                 ((state_q == READY) && !init));
  assign load_last = (state_q == LOAD) ? (cnt_q == '0) : (LB == 1);
  assign start     = (state_q == READY) && init;
  assign cnt_zero  = (cnt_q == '0);

  function automatic logic [ACC_W-1:0] z_post(input logic signed [ACC_W-1:0] v);
`ifdef TINYTPU_RELU_EN
    return v[ACC_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_fire) state_d = load_last ? READY : LOAD;
      LOAD:    if (load_fire && load_last) state_d = READY;
      READY: begin
        if (start)          state_d = COMPUTE;
        else if (load_fire) state_d = load_last ? READY : LOAD;
      end
      COMPUTE: if (cnt_zero) state_d = TX;
      TX:      if (!tx_hold && cnt_zero) state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state; data_out_z is gated to 0 outside TX.
  always_comb begin
    tx_ready   = (state_q == TX);
    load_done  = (state_q == READY);
    busy       = (state_q == COMPUTE) || (state_q == TX);
    data_out_z = (state_q == TX) ? z_sr_q[Z_W-1 -: LANES] : '0;
  end

  // Operand select for step k = N-1-cnt: row i of the array sees X[i][k], column j sees Y[k][j].
  always_comb begin
    for (int i = 0; i < N; i++) begin
      x_col[i] = '0;
      y_row[i] = '0;
      for (int kk = 0; kk < N; kk++) begin
        if (cnt_q == CNT_W'(N - 1 - kk)) begin
          x_col[i] = x_sr_q[(NN - (i * N + kk)) * D_W - 1 -: D_W];
          y_row[i] = y_sr_q[(NN - (kk * N + i)) * D_W - 1 -: D_W];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      tinytpu_mac_cell #(
        .D_W   (D_W),
        .ACC_W (ACC_W)
      ) u_cell (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (start),
        .en_i      (state_q == COMPUTE),
        .a_i       (x_col[gi]),
        .b_i       (y_row[gj]),
        .acc_nxt_o (acc_nxt[gi][gj])
      );
    end
  end

  // Pack final sums row-major with element [0][0] in the top bits of the TX shifter.
  always_comb begin
    z_load = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        z_load[(NN - (i * N + j)) * ACC_W - 1 -: ACC_W] = z_post(acc_nxt[i][j]);
      end
    end
  end

  // Datapath next-state: operand shifters, shared down-counter and TX shifter.
  always_comb begin
    cnt_d  = cnt_q;
    x_sr_d = x_sr_q;
    y_sr_d = y_sr_q;
    z_sr_d = z_sr_q;
    if (load_fire) begin
      x_sr_d = (x_sr_q << LANES) | OP_W'(data_in_x);
      y_sr_d = (y_sr_q << LANES) | OP_W'(data_in_y);
      if (load_last)             cnt_d = '0;
      else if (state_q == LOAD)  cnt_d = cnt_q - 1'b1;
      else                       cnt_d = CNT_W'(LB - 2);
    end
    if (start) cnt_d = CNT_W'(N - 1);
    if (state_q == COMPUTE) begin
      if (cnt_zero) begin
        cnt_d  = CNT_W'(TB - 1);
        z_sr_d = z_load;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    // The shifter empties itself as chunks leave, so it reads 0 once TX finishes.
    if ((state_q == TX) && !tx_hold) begin
      z_sr_d = z_sr_q << LANES;
      if (!cnt_zero) cnt_d = cnt_q - 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      x_sr_q <= '0;
      y_sr_q <= '0;
      z_sr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      x_sr_q <= x_sr_d;
      y_sr_q <= y_sr_d;
      z_sr_q <= z_sr_d;
    end
  end

endmodule

// File: tb/tb_tinytpu_mm_engine.sv
// Self-checking bench for tinytpu_mm_engine: directed and random matrices
// compared against a plain-arithmetic matrix product model.
module tb_tinytpu_mm_engine;

  localparam int D_W   = 8;
  localparam int N     = 2;
  localparam int LANES = 1;
  localparam int ACC_W = 2 * D_W + $clog2(N);
  localparam int NN    = N * N;
  localparam int LB    = NN * D_W / LANES;
  localparam int CPE   = ACC_W / LANES;

  logic             clk = 1'b0;
  logic             rst;
  logic [LANES-1:0] data_in_x, data_in_y;
  logic             load_en, init, tx_hold;
  logic [LANES-1:0] data_out_z;
  logic             tx_ready, load_done, busy;

  int n_checks = 0;
  int n_fail   = 0;

  int xm [N][N];
  int ym [N][N];
  logic [ACC_W-1:0] ez [NN];

  always #5 clk = ~clk;

  tinytpu_mm_engine #(
    .D_W   (D_W),
    .N     (N),
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in_x  (data_in_x),
    .data_in_y  (data_in_y),
    .load_en    (load_en),
    .init       (init),
    .tx_hold    (tx_hold),
    .data_out_z (data_out_z),
    .tx_ready   (tx_ready),
    .load_done  (load_done),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: Z = X*Y with optional ReLU, truncated to ACC_W bits.
  task automatic model_z();
    int s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += xm[i][k] * ym[k][j];
`ifdef TINYTPU_RELU_EN
        if (s < 0) s = 0;
`endif
        ez[i * N + j] = ACC_W'(s);
      end
    end
  endtask

  task automatic set_mats(input int x0, x1, x2, x3, y0, y1, y2, y3);
    xm[0][0] = x0; xm[0][1] = x1; xm[1][0] = x2; xm[1][1] = x3;
    ym[0][0] = y0; ym[0][1] = y1; ym[1][0] = y2; ym[1][1] = y3;
  endtask

  task automatic rand_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        xm[i][j] = int'($urandom_range(0, 255)) - 128;
        ym[i][j] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  // Serial load: row-major, MSB-first. Optional pause, random init noise inside
  // LOAD, or an abort by reset at chunk abort_at.
  task automatic load_mats(input int pause_at, input int pause_len,
                           input bit init_noise, input int abort_at);
    bit xq[$];
    bit yq[$];
    logic [31:0] vx, vy;
    for (int e = 0; e < NN; e++) begin
      vx = xm[e / N][e % N];
      vy = ym[e / N][e % N];
      for (int b = D_W - 1; b >= 0; b--) begin
        xq.push_back(vx[b]);
        yq.push_back(vy[b]);
      end
    end
    for (int c = 0; c < LB; c++) begin
      if (c == abort_at) begin
        rst = 1'b1; load_en = 1'b0; init = 1'b0;
        step();
        rst = 1'b0;
        chk("abort_load_done", load_done, 0);
        chk("abort_busy", busy, 0);
        return;
      end
      if (c == pause_at) begin
        chk("pause_load_done", load_done, 0);
        load_en = 1'b0;
        repeat (pause_len) begin
          data_in_x = LANES'($urandom);
          data_in_y = LANES'($urandom);
          init = init_noise ? 1'($urandom) : 1'b0;
          step();
        end
      end
      load_en = 1'b1;
      for (int l = 0; l < LANES; l++) begin
        data_in_x[LANES-1-l] = xq[c * LANES + l];
        data_in_y[LANES-1-l] = yq[c * LANES + l];
      end
      init = (init_noise && c > 0) ? 1'($urandom) : 1'b0;
      step();
    end
    load_en = 1'b0; init = 1'b0; data_in_x = '0; data_in_y = '0;
    chk("load_done", load_done, 1);
    chk("ready_busy", busy, 0);
  endtask

  // Pulse init (optionally with load_en also high) and check latency and stream.
  task automatic run_and_check(input string tag, input int hold_at, input int hold_len,
                               input bit with_load);
    logic [63:0]      elem;
    logic [LANES-1:0] chunk;
    model_z();
    init = 1'b1;
    load_en = with_load;
    data_in_x = LANES'($urandom);
    data_in_y = LANES'($urandom);
    step();
    init = 1'b0; load_en = 1'b0; data_in_x = '0; data_in_y = '0;
    chk("busy_compute", busy, 1);
    chk("txr_compute", tx_ready, 0);
    repeat (N - 1) step();
    chk("txr_before_lat", tx_ready, 0);
    step();
    for (int e = 0; e < NN; e++) begin
      elem = '0;
      for (int c = 0; c < CPE; c++) begin
        chk("tx_ready", tx_ready, 1);
        chunk = data_out_z;
        elem = (elem << LANES) | 64'(chunk);
        if ((e * CPE + c) == hold_at) begin
          tx_hold = 1'b1;
          repeat (hold_len) begin
            step();
            chk("hold_stable", data_out_z, chunk);
            chk("hold_txr", tx_ready, 1);
          end
          tx_hold = 1'b0;
        end
        step();
      end
      chk($sformatf("%s z%0d", tag, e), elem, 64'(ez[e]));
    end
    chk("end_txr", tx_ready, 0);
    chk("end_load_done", load_done, 1);
    chk("end_dout", data_out_z, 0);
    chk("end_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; init = 1'b0; tx_hold = 1'b0;
    data_in_x = '0; data_in_y = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_txr", tx_ready, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", data_out_z, 0);

    // init in IDLE must be ignored
    init = 1'b1; step(); init = 1'b0;
    chk("idle_init_busy", busy, 0);
    chk("idle_init_ld", load_done, 0);

    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    load_mats(-1, 0, 1'b0, -1);
    run_and_check("basic", -1, 0, 1'b0);

    set_mats(-1, 0, 0, 1, 3, 0, 0, 3);
    load_mats(-1, 0, 1'b0, -1);
    run_and_check("signed", -1, 0, 1'b0);

    set_mats(-128, -128, -128, -128, -128, -128, -128, -128);
    load_mats(-1, 0, 1'b0, -1);
    run_and_check("extreme", -1, 0, 1'b0);

    // pause mid-load and stall mid-TX
    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    load_mats(7, 5, 1'b1, -1);
    run_and_check("pause_hold", 20, 4, 1'b0);
    // second init reuses retained operands; init beats load_en
    run_and_check("reinit", -1, 0, 1'b0);
    run_and_check("init_wins", -1, 0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      rand_mats();
      load_mats(int'($urandom_range(1, LB - 1)), int'($urandom_range(0, 6)), 1'b1, -1);
      run_and_check($sformatf("rand%0d", t), int'($urandom_range(0, NN * CPE - 1)),
                    int'($urandom_range(0, 5)), 1'b0);
    end

    // reset mid-TX
    init = 1'b1; step(); init = 1'b0;
    repeat (N + 4) step();
    chk("pre_rst_txr", tx_ready, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midtx_rst_txr", tx_ready, 0);
    chk("midtx_rst_ld", load_done, 0);
    chk("midtx_rst_busy", busy, 0);
    chk("midtx_rst_dout", data_out_z, 0);
    init = 1'b1; step(); init = 1'b0;
    chk("post_rst_idle", busy, 0);

    // reset mid-load, then a full fresh load
    rand_mats();
    load_mats(-1, 0, 1'b0, 9);
    rand_mats();
    load_mats(-1, 0, 1'b0, -1);
    run_and_check("after_rst", 5, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
